// File: rtl/traffic_sensor_cond.sv
// Sensor conditioning ahead of the two-street light controller: sync, debounce, step tick, move outputs.
// Optional TRAFFIC_SENSOR_STRETCH_EN keeps each move output high for HOLD_TICKS ticks after its sensor clears.
module traffic_sensor_cond #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 8,
    parameter int HOLD_TICKS      = 2
) (
    input  logic CLK,
    input  logic reset,
    input  logic raw_a,
    input  logic raw_b,
    output logic tick,
    output logic move_a,
    output logic move_b,
    output logic db_a,
    output logic db_b
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    // Bit 0 is street A, bit 1 is street B throughout.
    logic [1:0]    w_raw;
    logic [1:0]    r_sync_p0;
    logic [1:0]    r_sync_p1;
    logic [1:0]    r_db;
    logic [DW-1:0] r_db_cnt [2];
    logic [TW-1:0] r_tick_cnt;
    logic          r_tick;
    logic [1:0]    r_move;
    logic          w_tick_next;

    assign w_raw       = {raw_b, raw_a};
    assign w_tick_next = (r_tick_cnt == TICK_LAST);

    // Stage p0/p1: two-flop synchroniser, then debounce on the p1 level.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            r_db      <= '0;
            for (int c = 0; c < 2; c++) begin
                r_db_cnt[c] <= '0;
            end
        end else begin
            r_sync_p0 <= w_raw;
            r_sync_p1 <= r_sync_p0;
            for (int c = 0; c < 2; c++) begin
                if (r_sync_p1[c] == r_db[c]) begin
                    r_db_cnt[c] <= '0;
                end else if (r_db_cnt[c] == DB_LAST) begin
                    r_db[c]     <= r_sync_p1[c];
                    r_db_cnt[c] <= '0;
                end else begin
                    r_db_cnt[c] <= r_db_cnt[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick     <= w_tick_next;
            r_tick_cnt <= w_tick_next ? '0 : r_tick_cnt + 1'b1;
        end
    end

`ifdef TRAFFIC_SENSOR_STRETCH_EN
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

    logic [HW-1:0] r_hold [2];

    // Moves are re-evaluated on the edge that raises tick, using the pre-edge debounced level.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_move <= '0;
            for (int c = 0; c < 2; c++) begin
                r_hold[c] <= '0;
            end
        end else if (w_tick_next) begin
            for (int c = 0; c < 2; c++) begin
                if (r_db[c]) begin
                    r_move[c] <= 1'b1;
                    r_hold[c] <= HOLD_LOAD;
                end else if (r_hold[c] != '0) begin
                    r_move[c] <= 1'b1;
                    r_hold[c] <= r_hold[c] - 1'b1;
                end else begin
                    r_move[c] <= 1'b0;
                end
            end
        end
    end
`else
    // Without stretching the hold depth has no effect.
    localparam int unused_hold_ticks = HOLD_TICKS;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_move <= '0;
        end else if (w_tick_next) begin
            r_move <= r_db;
        end
    end
`endif

    assign tick   = r_tick;
    assign move_a = r_move[0];
    assign move_b = r_move[1];
    assign db_a   = r_db[0];
    assign db_b   = r_db[1];

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Scoreboard bench for traffic_sensor_cond: directed phases push expected output snapshots,
// a monitor compares them at their cycle and flags any tick not scheduled.
module tb_traffic_sensor_cond;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    logic raw_a = 1'b0;
    logic raw_b = 1'b0;
    logic tick, move_a, move_b, db_a, db_b;

`ifdef TRAFFIC_SENSOR_STRETCH_EN
    localparam logic STR = 1'b1;
`else
    localparam logic STR = 1'b0;
`endif

    traffic_sensor_cond #(
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV       (8),
        .HOLD_TICKS     (2)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .raw_a (raw_a),
        .raw_b (raw_b),
        .tick  (tick),
        .move_a(move_a),
        .move_b(move_b),
        .db_a  (db_a),
        .db_b  (db_b)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic [4:0] val;   // {tick, move_a, move_b, db_a, db_b}
    } exp_t;

    exp_t exp_q[$];
    int   cyc = -1;
    int   total = 0;
    int   bad = 0;

    task automatic expect_at(input int c, input logic t, input logic ma, input logic mb,
                             input logic da, input logic dbb);
        exp_t e;
        e.cyc = c;
        e.val = {t, ma, mb, da, dbb};
        exp_q.push_back(e);
    endtask

    function automatic logic [1:0] raw_for(input int ph, input int c);
        logic a, b;
        a = 1'b0;
        b = 1'b0;
        case (ph)
            2: a = (c >= 10 && c <= 12);
            3: a = (c >= 10);
            4: begin a = (c >= 10); b = (c >= 10); end
            5: begin a = (c >= 2 && c < 30); b = (c >= 20 && c <= 23); end
            default: ;
        endcase
        return {b, a};
    endfunction

    task automatic do_reset();
        cyc   = -1;
        reset = 1'b1;
        raw_a = 1'b0;
        raw_b = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic run_phase(input int ph, input int last);
        do_reset();
        for (int c = 0; c <= last; c++) begin
            {raw_b, raw_a} = raw_for(ph, c);
            reset = (ph == 3 && c == 30);
            @(posedge CLK);
            #1;
            cyc = cyc + 1;
        end
        reset = 1'b0;
    endtask

    // Monitor: mid-cycle sampling on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (cyc >= 0) begin
                if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    total++;
                    if ({tick, move_a, move_b, db_a, db_b} !== e.val) begin
                        bad++;
                        $display("FAIL snapshot cyc=%0d tick/ma/mb/da/db actual=%b required=%b",
                                 cyc, {tick, move_a, move_b, db_a, db_b}, e.val);
                    end
                end else begin
                    total++;
                    if (tick !== 1'b0) begin
                        bad++;
                        $display("FAIL stray_tick cyc=%0d actual tick=%b required 0", cyc, tick);
                    end
                end
            end
        end
    end

    initial begin
        // Idle: ticks at 8/16/24, everything else low.
        expect_at(0,  0, 0, 0, 0, 0);
        expect_at(8,  1, 0, 0, 0, 0);
        expect_at(16, 1, 0, 0, 0, 0);
        expect_at(24, 1, 0, 0, 0, 0);
        run_phase(1, 26);

        // Three-cycle glitch on A is rejected.
        expect_at(0,  0, 0, 0, 0, 0);
        expect_at(8,  1, 0, 0, 0, 0);
        expect_at(15, 0, 0, 0, 0, 0);
        expect_at(16, 1, 0, 0, 0, 0);
        expect_at(24, 1, 0, 0, 0, 0);
        expect_at(32, 1, 0, 0, 0, 0);
        run_phase(2, 34);

        // A rises at 10, then reset at 30 with A still high.
        expect_at(0,  0, 0, 0, 0, 0);
        expect_at(8,  1, 0, 0, 0, 0);
        expect_at(15, 0, 0, 0, 0, 0);
        expect_at(16, 1, 0, 0, 1, 0);
        expect_at(24, 1, 1, 0, 1, 0);
        expect_at(30, 0, 1, 0, 1, 0);
        expect_at(31, 0, 0, 0, 0, 0);
        expect_at(36, 0, 0, 0, 0, 0);
        expect_at(37, 0, 0, 0, 1, 0);
        expect_at(39, 1, 1, 0, 1, 0);
        run_phase(3, 41);

        // A and B rise together.
        expect_at(0,  0, 0, 0, 0, 0);
        expect_at(8,  1, 0, 0, 0, 0);
        expect_at(15, 0, 0, 0, 0, 0);
        expect_at(16, 1, 0, 0, 1, 1);
        expect_at(24, 1, 1, 1, 1, 1);
        run_phase(4, 26);

        // A high 2..29 then falls; B exactly four cycles wide flips db_b between ticks.
        expect_at(0,  0, 0, 0, 0, 0);
        expect_at(8,  1, 0, 0, 1, 0);
        expect_at(16, 1, 1, 0, 1, 0);
        expect_at(24, 1, 1, 0, 1, 0);
        expect_at(26, 0, 1, 0, 1, 1);
        expect_at(30, 0, 1, 0, 1, 0);
        expect_at(32, 1, 1, 0, 1, 0);
        expect_at(37, 0, 1, 0, 0, 0);
        expect_at(40, 1, STR, 0, 0, 0);
        expect_at(48, 1, STR, 0, 0, 0);
        expect_at(56, 1, 0, 0, 0, 0);
        run_phase(5, 58);

        repeat (2) @(posedge CLK);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expectations actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
